// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// slave is the arbiter's view; master is everything around it (requesters plus memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, done0, gnt1, done1,
    output rdata, busy,
    output mem_addr, mem_wdata, mem_write
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, done0, gnt1, done1,
    input  rdata, busy,
    input  mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 single-port data memory: fetch (port 0) and
// load/store (port 1) share it, one registered access at a time, IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PRIO0 = (FIXED_PRIO != 0);

  state_t            state;
  logic              last;
  logic              owner;
  logic              wr;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done0_q;
  logic              done1_q;
  logic              busy_q;
  logic              gnt0_c;
  logic              gnt1_c;

  // Grants are only offered in IDLE; last==1 means port 1 was served most recently.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state == IDLE) begin
      gnt0_c = bus.req0 & (~bus.req1 | PRIO0 | last);
      gnt1_c = bus.req1 & ~gnt0_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      wr          <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done0_q     <= 1'b0;
          done1_q     <= 1'b0;
          mem_write_q <= 1'b0;
          if (gnt0_c) begin
            mem_addr_q  <= bus.addr0;
            mem_wdata_q <= bus.wdata0;
            wr          <= bus.we0;
            mem_write_q <= bus.we0;
            last        <= 1'b0;
            owner       <= 1'b0;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end else if (gnt1_c) begin
            mem_addr_q  <= bus.addr1;
            mem_wdata_q <= bus.wdata1;
            wr          <= bus.we1;
            mem_write_q <= bus.we1;
            last        <= 1'b1;
            owner       <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory has seen stable address/data for a full cycle; capture read data now.
          mem_write_q <= 1'b0;
          if (!wr) begin
            rdata_q <= bus.mem_rdata;
          end
          done0_q <= ~owner;
          done1_q <= owner;
          state   <= DONE;
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mem_write_q <= 1'b0;
          done0_q     <= 1'b0;
          done1_q     <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_write = mem_write_q;

endmodule
